regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port among N requesters: ALU writeback, LUT load and jump-register load.
- Round-robin arbitration with a valid/ready handshake per requester.
- One-cycle registered write stage drives the register file's write enable, write address and write data.
- Exports a per-register pending mask so decode can stall reads of registers with queued or in-flight writes.

Parameters:
- W, 8, data path width.
- A, 2, register address width; 2**A registers.
- N, 3, number of write requesters (≥2).

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- Hold  input  1  when high, no grants issued this cycle
- ReqValid  input  N  per-requester write request
- ReqAddr  input  N×A  per-requester target register (packed, requester i at [i*A +: A])
- ReqData  input  N×W  per-requester write data (packed, requester i at [i*W +: W])
- ReqReady  output  N  one-hot or zero; high for the requester granted this cycle
- WriteEn  output  1  registered write enable to register file
- Waddr  output  A  registered write address
- WData  output  W  registered write data
- WSrc  output  $clog2(N)  registered index of the requester that owns the current write
- Pending  output  2**A  bit r set if register r is targeted by any valid request or by the current write stage

Behaviour:
- Reset (synchronous, Reset=1 at rising edge): WriteEn=0, Waddr=0, WData=0, WSrc=0, RR pointer=0.
- ReqReady and Pending are combinational from inputs and state; with Reset held, ReqReady=0.
- Grant (combinational):
  - If Hold=0 and any ReqValid: grant the first valid requester scanning i = ptr, ptr+1, … mod N.
  - ReqReady[g]=1; all other ReqReady bits 0.
  - If Hold=1 or no ReqValid: ReqReady=0.
- Transfer occurs when ReqValid[i] & ReqReady[i]. Requester holds Valid/Addr/Data stable until its transfer. Dropping Valid before Ready is illegal; the bench flags it.
- Write stage (registered, latency 1):
  - On a transfer in cycle t: in cycle t+1, WriteEn=1, Waddr=ReqAddr[g], WData=ReqData[g], WSrc=g.
  - On a cycle with no transfer: WriteEn=0 next cycle; Waddr/WData/WSrc hold their last values.
- Pointer: after a transfer to g, ptr ← (g+1) mod N. No transfer: ptr unchanged. Hold does not move ptr.
- Throughput: one write per cycle, back-to-back.
- Fairness: a requester holding Valid with Hold=0 is granted within N cycles.
- Same-address requests in one cycle: both are served in round-robin order on consecutive cycles; the later write wins in the register file. No merging or dropping.
- Pending[r] = OR over i of (ReqValid[i] & ReqAddr[i]==r) OR (WriteEn & Waddr==r).
- Reset mid-operation: any request not yet transferred is discarded (requester re-presents it); an in-flight write stage is cancelled, so WriteEn=0 in the cycle after Reset.
- No internal queue beyond the write stage; back-pressure is entirely via ReqReady.

Decomposition:
- Package regfile_arb_pkg:
  - default W/A/N
  - requester index constants REQ_ALU=0, REQ_LUT=1, REQ_JMP=2
  - localparam SRC_W = $clog2(N)
- Sub-module rr_arbiter: combinational round-robin grant from valid vector and pointer, plus registered pointer update. Parameterised by N, with Clk/Reset/Hold ports.
- Write stage and Pending logic stay in the top module.

Test Plan:
- Reset then idle: Reset=1 one cycle, ReqValid=0 → WriteEn=0, ReqReady=000, Pending=0000 on every following cycle.
- Single request: ReqValid=001, ReqAddr[0]=2, ReqData[0]=8'hA5 → ReqReady=001 same cycle; next cycle WriteEn=1, Waddr=2, WData=A5, WSrc=0, Pending=0100.
- All three valid continuously, ptr=0 → grants 0,1,2,0,1,2 on consecutive cycles; WriteEn held 1; WSrc sequence 0,1,2,0,… one cycle later.
- Same-address collision: req0 (r1, 8'h11) and req2 (r1, 8'h22) valid together, ptr=1 → req2 granted first, then req0; writes 22 then 11; Pending[1]=1 until the cycle after the second write's stage.
- Hold: ReqValid=010 with Hold=1 for 3 cycles → ReqReady=000 and WriteEn=0 throughout; Hold drops → grant to 1 same cycle, write next cycle.
- Reset mid-stream: transfer req1 in cycle t, Reset=1 in cycle t+1 → WriteEn=0 at t+2, ptr=0, req1 re-presented is granted normally.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared constants for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int DEFAULT_W = 8;
  localparam int DEFAULT_A = 2;
  localparam int DEFAULT_N = 3;

  // Requester slots on the shared write port.
  localparam int REQ_ALU = 0;
  localparam int REQ_LUT = 1;
  localparam int REQ_JMP = 2;

  localparam int SRC_W = $clog2(DEFAULT_N);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator. The scan starts at the pointer. The pointer
// moves to one past the winner only when a grant is actually issued.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Hold,
  input  logic [N-1:0]  Valid,
  output logic [N-1:0]  Grant,
  output logic [SW-1:0] GrantIdx,
  output logic          GrantVld
);

  logic [SW-1:0]  ptr_q;
  logic [SW-1:0]  ptr_d;
  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [SW-1:0]  off_s;
  logic [SW:0]    sum_s;
  logic [SW-1:0]  win_s;
  logic           found_s;

  // Rotate the valid vector so bit 0 is the pointer slot, then find the first set bit.
  always_comb begin
    dbl_s   = {Valid, Valid} >> ptr_q;
    rot_s   = dbl_s[N-1:0];
    found_s = 1'b0;
    off_s   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        off_s   = SW'(k);
      end else begin
        found_s = found_s;
      end
    end
    sum_s = {1'b0, ptr_q} + {1'b0, off_s};
    if (sum_s >= (SW+1)'(N)) begin
      win_s = SW'(sum_s - (SW+1)'(N));
    end else begin
      win_s = sum_s[SW-1:0];
    end
  end

  // Issue the one-hot grant unless Hold or Reset suppresses it; compute the next pointer.
  always_comb begin
    GrantVld = found_s & ~Hold & ~Reset;
    GrantIdx = win_s;
    if (GrantVld) begin
      Grant = N'(1) << win_s;
      if (win_s == SW'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_s + SW'(1);
      end
    end else begin
      Grant = '0;
      ptr_d = ptr_q;
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among N requesters.
// A round-robin grant feeds a one-cycle registered write stage.
// The Pending mask lets decode stall reads of registers with queued or in-flight writes.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int A  = DEFAULT_A,
  parameter int N  = DEFAULT_N,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Hold,
  input  logic [N-1:0]      ReqValid,
  input  logic [N*A-1:0]    ReqAddr,
  input  logic [N*W-1:0]    ReqData,
  output logic [N-1:0]      ReqReady,
  output logic              WriteEn,
  output logic [A-1:0]      Waddr,
  output logic [W-1:0]      WData,
  output logic [SW-1:0]     WSrc,
  output logic [2**A-1:0]   Pending
);

  logic [N-1:0]    grant_s;
  logic [SW-1:0]   grant_idx_s;
  logic            xfer_s;
  logic [A-1:0]    sel_addr_s;
  logic [W-1:0]    sel_data_s;
  logic [2**A-1:0] pend_s;

  logic            we_q,    we_d;
  logic [A-1:0]    waddr_q, waddr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]   wsrc_q,  wsrc_d;

  rr_arbiter #(.N(N), .SW(SW)) u_rr (
    .Clk      (Clk),
    .Reset    (Reset),
    .Hold     (Hold),
    .Valid    (ReqValid),
    .Grant    (grant_s),
    .GrantIdx (grant_idx_s),
    .GrantVld (xfer_s)
  );

  // Select the winning requester's address and data from the one-hot grant.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_s[i]) begin
        sel_addr_s = ReqAddr[i*A +: A];
        sel_data_s = ReqData[i*W +: W];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // Next write-stage contents: load on a transfer; otherwise drop the enable and hold the fields.
  always_comb begin
    we_d = xfer_s;
    if (xfer_s) begin
      waddr_d = sel_addr_s;
      wdata_d = sel_data_s;
      wsrc_d  = grant_idx_s;
    end else begin
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wsrc_d  = wsrc_q;
    end
  end

  // Write-stage registers; reset also cancels an in-flight write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wsrc_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wsrc_q  <= wsrc_d;
    end
  end

  // A register is pending if any valid request or the current write stage targets it.
  always_comb begin
    pend_s = '0;
    for (int r = 0; r < 2**A; r++) begin
      pend_s[r] = we_q && (waddr_q == A'(r));
      for (int i = 0; i < N; i++) begin
        if (ReqValid[i] && (ReqAddr[i*A +: A] == A'(r))) begin
          pend_s[r] = 1'b1;
        end else begin
          pend_s[r] = pend_s[r];
        end
      end
    end
  end

  assign ReqReady = grant_s;
  assign WriteEn  = we_q;
  assign Waddr    = waddr_q;
  assign WData    = wdata_q;
  assign WSrc     = wsrc_q;
  assign Pending  = pend_s;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed table and random bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int W  = 8;
  localparam int A  = 2;
  localparam int N  = 3;
  localparam int NR = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Hold;
  logic [N-1:0]  ReqValid;
  logic [N*A-1:0] ReqAddr;
  logic [N*W-1:0] ReqData;
  logic [N-1:0]  ReqReady;
  logic          WriteEn;
  logic [A-1:0]  Waddr;
  logic [W-1:0]  WData;
  logic [1:0]    WSrc;
  logic [NR-1:0] Pending;

  always #5 Clk = ~Clk;

  regfile_write_arbiter #(.W(W), .A(A), .N(N)) dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .ReqReady(ReqReady), .WriteEn(WriteEn), .Waddr(Waddr),
    .WData(WData), .WSrc(WSrc), .Pending(Pending)
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic [2:0]  v;
    logic [5:0]  a;
    logic [23:0] d;
    logic [2:0]  rdy;
    logic        we;
    logic [1:0]  waddr;
    logic [7:0]  wdata;
    logic [1:0]  wsrc;
    logic [3:0]  pend;
  } vec_t;

  vec_t tbl[32];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: the architectural view of the write stage and pointer.
  int          m_ptr;
  logic        m_we;
  logic [1:0]  m_waddr;
  logic [7:0]  m_wdata;
  logic [1:0]  m_wsrc;
  logic [2:0]  prev_v    = 3'b000;
  logic [2:0]  prev_r    = 3'b000;
  logic        prev_rst  = 1'b1;
  int          waitc[N];

  function automatic vec_t mk(input logic rst, hold, input logic [2:0] v, input logic [5:0] a,
                              input logic [23:0] d, input logic [2:0] rdy, input logic we,
                              input logic [1:0] waddr, input logic [7:0] wdata,
                              input logic [1:0] wsrc, input logic [3:0] pend);
    vec_t t;
    t.rst = rst; t.hold = hold; t.v = v; t.a = a; t.d = d; t.rdy = rdy;
    t.we = we; t.waddr = waddr; t.wdata = wdata; t.wsrc = wsrc; t.pend = pend;
    return t;
  endfunction

  // First valid requester scanning from the pointer, or -1 when nothing may be granted.
  function automatic int model_grant();
    if (Reset || Hold) return -1;
    for (int k = 0; k < N; k++) begin
      if (ReqValid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_pend();
    logic [3:0] p = 4'h0;
    for (int r = 0; r < NR; r++) begin
      if (m_we && int'(m_waddr) == r) p[r] = 1'b1;
      for (int i = 0; i < N; i++)
        if (ReqValid[i] && int'(ReqAddr[i*A +: A]) == r) p[r] = 1'b1;
    end
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, hold, input logic [2:0] v, input logic [5:0] a,
                       input logic [23:0] d);
    logic [2:0] dropped;
    Reset = rst; Hold = hold; ReqValid = v; ReqAddr = a; ReqData = d;
    #1;
    dropped = prev_rst ? 3'b000 : (prev_v & ~prev_r & ~v);
    chk("protocol_drop", 32'(dropped), 32'd0);
  endtask

  task automatic check_model();
    int g;
    logic [2:0] er;
    g  = model_grant();
    er = (g < 0) ? 3'b000 : 3'(1 << g);
    chk("ready",   32'(ReqReady), 32'(er));
    chk("we",      32'(WriteEn),  32'(m_we));
    chk("waddr",   32'(Waddr),    32'(m_waddr));
    chk("wdata",   32'(WData),    32'(m_wdata));
    chk("wsrc",    32'(WSrc),     32'(m_wsrc));
    chk("pending", 32'(Pending),  32'(model_pend()));
  endtask

  // Update the model for the coming edge, track fairness, then step one clock.
  task automatic advance();
    int g;
    int worst;
    g = model_grant();
    worst = 0;
    for (int i = 0; i < N; i++) begin
      if (Reset || !ReqValid[i] || ReqReady[i]) waitc[i] = 0;
      else if (!Hold) waitc[i]++;
      if (waitc[i] > worst) worst = waitc[i];
    end
    chk("fairness", 32'(worst > N - 1), 32'd0);
    prev_v   = ReqValid;
    prev_r   = (g < 0) ? 3'b000 : 3'(1 << g);
    prev_rst = Reset;
    if (Reset) begin
      m_we = 1'b0; m_waddr = 2'd0; m_wdata = 8'h00; m_wsrc = 2'd0; m_ptr = 0;
    end else if (g >= 0) begin
      m_we = 1'b1; m_waddr = ReqAddr[g*A +: A]; m_wdata = ReqData[g*W +: W];
      m_wsrc = 2'(g); m_ptr = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic        r_rst, r_hold;
    logic [2:0]  r_v;
    logic [5:0]  r_a;
    logic [23:0] r_d;

    for (int i = 0; i < N; i++) waitc[i] = 0;
    m_ptr = 0;

    //             rst  hold v       addr   data          rdy     we    waddr wdata  wsrc  pend
    tbl[0]  = mk(1'b1,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b0,2'd0,8'h00,2'd0,4'h0);
    tbl[1]  = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b0,2'd0,8'h00,2'd0,4'h0);
    tbl[2]  = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b0,2'd0,8'h00,2'd0,4'h0);
    tbl[3]  = mk(1'b0,1'b0,3'b001,6'h02,24'h0000A5, 3'b001,1'b0,2'd0,8'h00,2'd0,4'h4);
    tbl[4]  = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b1,2'd2,8'hA5,2'd0,4'h4);
    tbl[5]  = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b0,2'd2,8'hA5,2'd0,4'h0);
    tbl[6]  = mk(1'b1,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b0,2'd2,8'hA5,2'd0,4'h0);
    tbl[7]  = mk(1'b0,1'b0,3'b111,6'h34,24'h302010, 3'b001,1'b0,2'd0,8'h00,2'd0,4'hB);
    tbl[8]  = mk(1'b0,1'b0,3'b111,6'h34,24'h302010, 3'b010,1'b1,2'd0,8'h10,2'd0,4'hB);
    tbl[9]  = mk(1'b0,1'b0,3'b111,6'h34,24'h302010, 3'b100,1'b1,2'd1,8'h20,2'd1,4'hB);
    tbl[10] = mk(1'b0,1'b0,3'b111,6'h34,24'h302010, 3'b001,1'b1,2'd3,8'h30,2'd2,4'hB);
    tbl[11] = mk(1'b0,1'b0,3'b111,6'h34,24'h302010, 3'b010,1'b1,2'd0,8'h10,2'd0,4'hB);
    tbl[12] = mk(1'b0,1'b0,3'b111,6'h34,24'h302010, 3'b100,1'b1,2'd1,8'h20,2'd1,4'hB);
    tbl[13] = mk(1'b0,1'b0,3'b011,6'h34,24'h302010, 3'b001,1'b1,2'd3,8'h30,2'd2,4'hB);
    tbl[14] = mk(1'b0,1'b0,3'b010,6'h34,24'h302010, 3'b010,1'b1,2'd0,8'h10,2'd0,4'h3);
    tbl[15] = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b1,2'd1,8'h20,2'd1,4'h2);
    tbl[16] = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b0,2'd1,8'h20,2'd1,4'h0);
    tbl[17] = mk(1'b0,1'b0,3'b001,6'h00,24'h000001, 3'b001,1'b0,2'd1,8'h20,2'd1,4'h1);
    tbl[18] = mk(1'b0,1'b0,3'b101,6'h11,24'h220011, 3'b100,1'b1,2'd0,8'h01,2'd0,4'h3);
    tbl[19] = mk(1'b0,1'b0,3'b001,6'h11,24'h220011, 3'b001,1'b1,2'd1,8'h22,2'd2,4'h2);
    tbl[20] = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b1,2'd1,8'h11,2'd0,4'h2);
    tbl[21] = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b0,2'd1,8'h11,2'd0,4'h0);
    tbl[22] = mk(1'b0,1'b1,3'b010,6'h08,24'h005A00, 3'b000,1'b0,2'd1,8'h11,2'd0,4'h4);
    tbl[23] = mk(1'b0,1'b1,3'b010,6'h08,24'h005A00, 3'b000,1'b0,2'd1,8'h11,2'd0,4'h4);
    tbl[24] = mk(1'b0,1'b1,3'b010,6'h08,24'h005A00, 3'b000,1'b0,2'd1,8'h11,2'd0,4'h4);
    tbl[25] = mk(1'b0,1'b0,3'b010,6'h08,24'h005A00, 3'b010,1'b0,2'd1,8'h11,2'd0,4'h4);
    tbl[26] = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b1,2'd2,8'h5A,2'd1,4'h4);
    tbl[27] = mk(1'b0,1'b0,3'b010,6'h0C,24'h007700, 3'b010,1'b0,2'd2,8'h5A,2'd1,4'h8);
    tbl[28] = mk(1'b1,1'b0,3'b010,6'h0C,24'h007700, 3'b000,1'b1,2'd3,8'h77,2'd1,4'h8);
    tbl[29] = mk(1'b0,1'b0,3'b010,6'h0C,24'h007700, 3'b010,1'b0,2'd0,8'h00,2'd0,4'h8);
    tbl[30] = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b1,2'd3,8'h77,2'd1,4'h8);
    tbl[31] = mk(1'b0,1'b0,3'b000,6'h00,24'h000000, 3'b000,1'b0,2'd3,8'h77,2'd1,4'h0);

    // Initial reset brings the write stage out of its unknown power-up state.
    Reset = 1'b1; Hold = 1'b0; ReqValid = '0; ReqAddr = '0; ReqData = '0;
    @(posedge Clk);
    #1;
    drive(1'b1, 1'b0, 3'b000, 6'h00, 24'h000000);
    advance();

    // Directed table: fixed expected values per cycle.
    for (int k = 0; k < 32; k++) begin
      drive(tbl[k].rst, tbl[k].hold, tbl[k].v, tbl[k].a, tbl[k].d);
      chk($sformatf("row%0d ready", k),   32'(ReqReady), 32'(tbl[k].rdy));
      chk($sformatf("row%0d we", k),      32'(WriteEn),  32'(tbl[k].we));
      chk($sformatf("row%0d waddr", k),   32'(Waddr),    32'(tbl[k].waddr));
      chk($sformatf("row%0d wdata", k),   32'(WData),    32'(tbl[k].wdata));
      chk($sformatf("row%0d wsrc", k),    32'(WSrc),     32'(tbl[k].wsrc));
      chk($sformatf("row%0d pending", k), 32'(Pending),  32'(tbl[k].pend));
      advance();
    end

    // Random traffic against the reference model; requesters hold stable until granted.
    r_v = 3'b000; r_a = 6'h00; r_d = 24'h000000;
    for (int n = 0; n < 1500; n++) begin
      r_rst  = ($urandom_range(0, 49) == 0);
      r_hold = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(prev_v[i] && !prev_r[i] && !prev_rst)) begin
          r_v[i]         = ($urandom_range(0, 2) != 0);
          r_a[i*A +: A]  = 2'($urandom_range(0, 3));
          r_d[i*W +: W]  = 8'($urandom_range(0, 255));
        end
      end
      drive(r_rst, r_hold, r_v, r_a, r_d);
      check_model();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
